// File: rtl/map_ss_seq_if.sv
// Save-state bus bundle: mapper slot port plus the buffer-memory req/ack port.
// The master side is the sequencer; the slave side is the mapper/memory pair.
interface map_ss_seq_if #(
  parameter int MEM_AW = 16
) ();
  logic              ss_act;
  logic              ss_we;
  logic [7:0]        ss_addr;
  logic [7:0]        ss_wdat;
  logic [7:0]        ss_rdat;
  logic              mem_req;
  logic              mem_we;
  logic [MEM_AW-1:0] mem_addr;
  logic [7:0]        mem_wdat;
  logic [7:0]        mem_rdat;
  logic              mem_ack;

  modport master (
    output ss_act, ss_we, ss_addr, ss_wdat,
    input  ss_rdat,
    output mem_req, mem_we, mem_addr, mem_wdat,
    input  mem_rdat, mem_ack
  );

  modport slave (
    input  ss_act, ss_we, ss_addr, ss_wdat,
    output ss_rdat,
    input  mem_req, mem_we, mem_addr, mem_wdat,
    output mem_rdat, mem_ack
  );
endinterface

// File: rtl/map_ss_seq.sv
// Mapper save-state sequencer: copies mapper slots to a byte buffer (save) and replays them (load).
// Build macro SS_IDX_CHECK_EN: a load first compares the stored mapper index against the live one.
module map_ss_seq #(
  parameter int SS_REGS  = 16,
  parameter int MEM_AW   = 16,
  parameter int IDX_ADDR = 127
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_save,
  input  logic              cmd_load,
  input  logic [MEM_AW-1:0] cmd_base,
  output logic              busy,
  output logic              done,
  output logic              err,
  map_ss_seq_if.master      bus
);

  localparam logic [7:0] REG_CNT  = 8'(SS_REGS);
  localparam logic [7:0] LAST_IDX = 8'(SS_REGS - 1);
  localparam logic [7:0] IDX_SLOT = 8'(IDX_ADDR);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_S_RD    = 3'd1,
    ST_S_REQ   = 3'd2,
    ST_L_REQ   = 3'd3,
    ST_L_WR    = 3'd4,
    ST_DONE    = 3'd5
`ifdef SS_IDX_CHECK_EN
    , ST_CHK_REQ = 3'd6
    , ST_CHK_CMP = 3'd7
`endif
  } state_t;

  state_t            state_r, state_s;
  logic [7:0]        index_r, index_s;
  logic [MEM_AW-1:0] base_r, base_s;
  logic              err_r, err_s;
  logic [7:0]        mem_wdat_r, mem_wdat_s;
  logic [7:0]        ss_wdat_r, ss_wdat_s;

  logic              busy_s, done_s, ss_act_s, ss_we_s, mem_req_s, mem_we_s;
  logic [7:0]        ss_addr_s;
  logic [MEM_AW-1:0] mem_addr_s;
  logic              ss_act_r, ss_we_r, mem_req_r, mem_we_r;
  logic [7:0]        ss_addr_r;
  logic [MEM_AW-1:0] mem_addr_r;

  // The slot after the last register is the read-only mapper-index slot.
  function automatic logic [7:0] slot_addr(input logic [7:0] idx);
    return (idx == REG_CNT) ? IDX_SLOT : idx;
  endfunction

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r    <= ST_IDLE;
      index_r    <= 8'd0;
      base_r     <= '0;
      err_r      <= 1'b0;
      mem_wdat_r <= 8'd0;
      ss_wdat_r  <= 8'd0;
    end else begin
      state_r    <= state_s;
      index_r    <= index_s;
      base_r     <= base_s;
      err_r      <= err_s;
      mem_wdat_r <= mem_wdat_s;
      ss_wdat_r  <= ss_wdat_s;
    end
  end

  // Next-state and datapath update.
  always_comb begin
    state_s    = state_r;
    index_s    = index_r;
    base_s     = base_r;
    err_s      = err_r;
    mem_wdat_s = mem_wdat_r;
    ss_wdat_s  = ss_wdat_r;
    case (state_r)
      ST_IDLE: begin
        if (cmd_save && cmd_load) begin
          err_s = 1'b1;
        end else if (cmd_save || cmd_load) begin
          base_s  = cmd_base;
          err_s   = 1'b0;
          index_s = 8'd0;
          if (cmd_save) begin
            state_s = ST_S_RD;
          end else begin
`ifdef SS_IDX_CHECK_EN
            state_s = ST_CHK_REQ;
`else
            state_s = ST_L_REQ;
`endif
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_S_RD: begin
        mem_wdat_s = bus.ss_rdat;
        state_s    = ST_S_REQ;
      end
      ST_S_REQ: begin
        if (bus.mem_ack) begin
          if (index_r == REG_CNT) begin
            state_s = ST_DONE;
          end else begin
            index_s = index_r + 8'd1;
            state_s = ST_S_RD;
          end
        end else begin
          state_s = ST_S_REQ;
        end
      end
      ST_L_REQ: begin
        if (bus.mem_ack) begin
          ss_wdat_s = bus.mem_rdat;
          state_s   = ST_L_WR;
        end else begin
          state_s = ST_L_REQ;
        end
      end
      ST_L_WR: begin
        index_s = index_r + 8'd1;
        if (index_r == LAST_IDX) begin
          state_s = ST_DONE;
        end else begin
          state_s = ST_L_REQ;
        end
      end
`ifdef SS_IDX_CHECK_EN
      // The stored index byte parks in ss_wdat_r; ss_we stays low so the mapper ignores it.
      ST_CHK_REQ: begin
        if (bus.mem_ack) begin
          ss_wdat_s = bus.mem_rdat;
          state_s   = ST_CHK_CMP;
        end else begin
          state_s = ST_CHK_REQ;
        end
      end
      ST_CHK_CMP: begin
        if (ss_wdat_r != bus.ss_rdat) begin
          err_s   = 1'b1;
          state_s = ST_DONE;
        end else begin
          index_s = 8'd0;
          state_s = ST_L_REQ;
        end
      end
`endif
      ST_DONE: begin
        state_s = ST_IDLE;
      end
      default: begin
        state_s = ST_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every port comes straight from a flop.
  always_comb begin
    busy_s     = 1'b0;
    done_s     = 1'b0;
    ss_act_s   = 1'b0;
    ss_we_s    = 1'b0;
    ss_addr_s  = 8'd0;
    mem_req_s  = 1'b0;
    mem_we_s   = 1'b0;
    mem_addr_s = '0;
    case (state_s)
      ST_IDLE: begin
        done_s = (state_r == ST_IDLE) && cmd_save && cmd_load;
      end
      ST_S_RD: begin
        busy_s    = 1'b1;
        ss_act_s  = 1'b1;
        ss_addr_s = slot_addr(index_s);
      end
      ST_S_REQ: begin
        busy_s     = 1'b1;
        ss_act_s   = 1'b1;
        ss_addr_s  = slot_addr(index_s);
        mem_req_s  = 1'b1;
        mem_we_s   = 1'b1;
        mem_addr_s = base_s + MEM_AW'(index_s);
      end
      ST_L_REQ: begin
        busy_s     = 1'b1;
        ss_act_s   = 1'b1;
        ss_addr_s  = index_s;
        mem_req_s  = 1'b1;
        mem_addr_s = base_s + MEM_AW'(index_s);
      end
      ST_L_WR: begin
        busy_s    = 1'b1;
        ss_act_s  = 1'b1;
        ss_addr_s = index_s;
        ss_we_s   = 1'b1;
      end
`ifdef SS_IDX_CHECK_EN
      ST_CHK_REQ: begin
        busy_s     = 1'b1;
        ss_act_s   = 1'b1;
        ss_addr_s  = IDX_SLOT;
        mem_req_s  = 1'b1;
        mem_addr_s = base_s + MEM_AW'(REG_CNT);
      end
      ST_CHK_CMP: begin
        busy_s    = 1'b1;
        ss_act_s  = 1'b1;
        ss_addr_s = IDX_SLOT;
      end
`endif
      ST_DONE: begin
        done_s = 1'b1;
      end
      default: begin
        done_s = 1'b0;
      end
    endcase
  end

  // Output registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      busy       <= 1'b0;
      done       <= 1'b0;
      ss_act_r   <= 1'b0;
      ss_we_r    <= 1'b0;
      ss_addr_r  <= 8'd0;
      mem_req_r  <= 1'b0;
      mem_we_r   <= 1'b0;
      mem_addr_r <= '0;
    end else begin
      busy       <= busy_s;
      done       <= done_s;
      ss_act_r   <= ss_act_s;
      ss_we_r    <= ss_we_s;
      ss_addr_r  <= ss_addr_s;
      mem_req_r  <= mem_req_s;
      mem_we_r   <= mem_we_s;
      mem_addr_r <= mem_addr_s;
    end
  end

  assign err          = err_r;
  assign bus.ss_act   = ss_act_r;
  assign bus.ss_we    = ss_we_r;
  assign bus.ss_addr  = ss_addr_r;
  assign bus.ss_wdat  = ss_wdat_r;
  assign bus.mem_req  = mem_req_r;
  assign bus.mem_we   = mem_we_r;
  assign bus.mem_addr = mem_addr_r;
  assign bus.mem_wdat = mem_wdat_r;

endmodule
